wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage of the RV32I pipeline. Latches MEM-stage results and formats load data
//  (LB/LH/LW/LBU/LHU). Drives the register file write port (ws/wd/wv) and counts retired
//  instructions. Also bypasses the register file's 1-cycle synchronous read, so decode
//  always sees coherent operands when a write hits a register being (or just) read.
// PARAMETERS
//  XLEN    32  datapath width
//  CNT_W   32  width of retired-instruction counter
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  in_v_i       in   1      MEM result valid
//  in_ready_o   out  1      stage can accept (= ~hold_i)
//  in_rd_i      in   5      destination register
//  in_we_i      in   1      instruction writes rd
//  in_load_i    in   1      result comes from memory
//  in_funct3_i  in   3      load size/sign
//  in_alo_i     in   2      address bits [1:0] of the load
//  in_alu_i     in   XLEN   ALU/PC+4 result
//  in_mdata_i   in   XLEN   raw 32-bit memory word
//  hold_i       in   1      freeze stage (debug/halt)
//  flush_i      in   1      kill the held entry and the incoming beat
//  rf_wv_o      out  1      register file write enable
//  rf_ws_o      out  5      register file write address
//  rf_wd_o      out  XLEN   register file write data
//  rf_rv_i      in   1      decode read strobe (same as regfile rv)
//  rf_rs1_i     in   5      decode rs1 (same as regfile rs1)
//  rf_rs2_i     in   5      decode rs2
//  rf_rd1_i     in   XLEN   raw regfile rd1
//  rf_rd2_i     in   XLEN   raw regfile rd2
//  rd1_o        out  XLEN   coherent operand 1 to decode/execute
//  rd2_o        out  XLEN   coherent operand 2
//  instret_o    out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset (reset=0, async): s_valid=0, rs1_q=rs2_q=0, byp1_v=byp2_v=0, instret=0.
//   rf_wv_o=0. rd1_o/rd2_o=0 (rs_q=0).
//  Capture: at an edge with in_v_i & in_ready_o & ~flush_i, the stage register loads all in_*
//   and sets s_valid=1. Otherwise, if not holding, s_valid<=0. With hold_i=1 and no flush,
//   contents are kept.
//  Write: rf_wv_o = s_valid & s_we & (s_rd!=0) & ~hold_i & ~flush_i. rf_ws_o=s_rd.
//   Latency: accepted at edge E, written to regfile at edge E+1.
//  flush_i: rf_wv_o=0 that cycle; s_valid<=0; no capture. flush_i overrides hold_i.
//  Retire: instret increments when s_valid & ~hold_i & ~flush_i, whether or not rd is written.
//   Wraps 2^CNT_W-1 -> 0.
//  Load format (s_load=1), w=s_mdata:
//   000 LB   sext(w.byte[alo])
//   001 LH   sext(w.half[alo[1]]); alo[0] ignored
//   010 LW   w
//   100 LBU  zext(w.byte[alo])
//   101 LHU  zext(w.half[alo[1]])
//   other    w
//   s_load=0: rf_wd_o=s_alu.
//  Bypass (per port n=1,2):
//   - rf_rv_i=1 at an edge: rs_n_q<=rf_rsn_i. byp_n_v<=(rf_wv_o & rf_ws_o==rf_rsn_i);
//     byp_n_d<=rf_wd_o.
//   - rf_rv_i=0 at an edge: regfile holds its output. If rf_wv_o & rf_ws_o==rs_n_q, set
//     byp_n_v<=1 and byp_n_d<=rf_wd_o (the latest write wins). Otherwise hold.
//   - rdn_o = (rs_n_q==0) ? 0 : byp_n_v ? byp_n_d : rf_rdn_i.
//   - rs1==rs2 is legal; both ports bypass independently and identically.
//  No combinational path from in_* to rf_*_o. rd*_o depend combinationally only on rf_rd*_i
//   and the stage's own flops.
// TESTING
//  T1 ALU wb: in_v, rd=5, we=1, alu=0x1234 -> next cycle rf_wv=1, ws=5, wd=0x1234; instret=1.
//  T2 loads: mdata=0x80FF7F01.
//   LB alo=2 -> 0xFFFFFFFF
//   LBU alo=3 -> 0x00000080
//   LH alo=0 -> 0x00007F01
//   LH alo=2 -> 0xFFFF80FF
//   LHU alo=2 -> 0x000080FF
//  T3 x0/no-we: rd=0 we=1 -> rf_wv=0, instret +1. rd=7 we=0 -> rf_wv=0, instret +1.
//  T4 same-cycle RAW: rv=1 rs1=9 while write x9=0xAA -> next cycle rd1_o=0xAA, even though the
//   raw regfile output returns the stale value.
//  T5 held read: rv=1 rs2=4, then rv=0 and a write x4=0x55 -> rd2_o=0x55 the cycle after.
//   rs=0 always gives 0.
//  T6 hold/flush/reset: hold 3 cycles -> no write, count frozen, write on release. Flush with
//   valid entry -> no write, no count. reset=0 mid-entry -> rf_wv=0 and instret=0 immediately.

Source files
------------

// File: rtl/wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_stage                                                     |
// | Description : RV32I writeback stage. Latches MEM results, formats loads,   |
// |               drives the regfile write port, counts retired instructions   |
// |               and bypasses the regfile's synchronous read so decode always |
// |               sees coherent operands.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_v_i,
  output logic             in_ready_o,
  input  logic [4:0]       in_rd_i,
  input  logic             in_we_i,
  input  logic             in_load_i,
  input  logic [2:0]       in_funct3_i,
  input  logic [1:0]       in_alo_i,
  input  logic [XLEN-1:0]  in_alu_i,
  input  logic [XLEN-1:0]  in_mdata_i,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic             rf_wv_o,
  output logic [4:0]       rf_ws_o,
  output logic [XLEN-1:0]  rf_wd_o,
  input  logic             rf_rv_i,
  input  logic [4:0]       rf_rs1_i,
  input  logic [4:0]       rf_rs2_i,
  input  logic [XLEN-1:0]  rf_rd1_i,
  input  logic [XLEN-1:0]  rf_rd2_i,
  output logic [XLEN-1:0]  rd1_o,
  output logic [XLEN-1:0]  rd2_o,
  output logic [CNT_W-1:0] instret_o
);

  logic             s_valid_q, s_valid_d;
  logic [4:0]       s_rd_q, s_rd_d;
  logic             s_we_q, s_we_d;
  logic             s_load_q, s_load_d;
  logic [2:0]       s_funct3_q, s_funct3_d;
  logic [1:0]       s_alo_q, s_alo_d;
  logic [XLEN-1:0]  s_alu_q, s_alu_d;
  logic [XLEN-1:0]  s_mdata_q, s_mdata_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d;
  logic             byp1_v_q, byp1_v_d, byp2_v_q, byp2_v_d;
  logic [XLEN-1:0]  byp1_d_q, byp1_d_d, byp2_d_q, byp2_d_d;

  logic             capture;
  logic             retire;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  assign in_ready_o = ~hold_i;
  assign capture    = in_v_i & ~hold_i & ~flush_i;
  assign retire     = s_valid_q & ~hold_i & ~flush_i;

  // Stage register, retire counter and read-port tracking next-state.
  always_comb begin
    s_valid_d  = s_valid_q;
    s_rd_d     = s_rd_q;
    s_we_d     = s_we_q;
    s_load_d   = s_load_q;
    s_funct3_d = s_funct3_q;
    s_alo_d    = s_alo_q;
    s_alu_d    = s_alu_q;
    s_mdata_d  = s_mdata_q;
    if (flush_i) begin
      s_valid_d = 1'b0;
    end else if (capture) begin
      s_valid_d  = 1'b1;
      s_rd_d     = in_rd_i;
      s_we_d     = in_we_i;
      s_load_d   = in_load_i;
      s_funct3_d = in_funct3_i;
      s_alo_d    = in_alo_i;
      s_alu_d    = in_alu_i;
      s_mdata_d  = in_mdata_i;
    end else if (!hold_i) begin
      s_valid_d = 1'b0;
    end

    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};

    // A new read samples the write in flight; while the regfile holds its
    // output, any later write to the held register replaces the bypass value.
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    byp1_v_d = byp1_v_q;
    byp2_v_d = byp2_v_q;
    byp1_d_d = byp1_d_q;
    byp2_d_d = byp2_d_q;
    if (rf_rv_i) begin
      rs1_d    = rf_rs1_i;
      rs2_d    = rf_rs2_i;
      byp1_v_d = rf_wv_o & (rf_ws_o == rf_rs1_i);
      byp2_v_d = rf_wv_o & (rf_ws_o == rf_rs2_i);
      byp1_d_d = rf_wd_o;
      byp2_d_d = rf_wd_o;
    end else begin
      if (rf_wv_o && (rf_ws_o == rs1_q)) begin
        byp1_v_d = 1'b1;
        byp1_d_d = rf_wd_o;
      end
      if (rf_wv_o && (rf_ws_o == rs2_q)) begin
        byp2_v_d = 1'b1;
        byp2_d_d = rf_wd_o;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_valid_q  <= 1'b0;
      s_rd_q     <= '0;
      s_we_q     <= 1'b0;
      s_load_q   <= 1'b0;
      s_funct3_q <= '0;
      s_alo_q    <= '0;
      s_alu_q    <= '0;
      s_mdata_q  <= '0;
      instret_q  <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      byp1_v_q   <= 1'b0;
      byp2_v_q   <= 1'b0;
      byp1_d_q   <= '0;
      byp2_d_q   <= '0;
    end else begin
      s_valid_q  <= s_valid_d;
      s_rd_q     <= s_rd_d;
      s_we_q     <= s_we_d;
      s_load_q   <= s_load_d;
      s_funct3_q <= s_funct3_d;
      s_alo_q    <= s_alo_d;
      s_alu_q    <= s_alu_d;
      s_mdata_q  <= s_mdata_d;
      instret_q  <= instret_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      byp1_v_q   <= byp1_v_d;
      byp2_v_q   <= byp2_v_d;
      byp1_d_q   <= byp1_d_d;
      byp2_d_q   <= byp2_d_d;
    end
  end

  // Load formatting: pick the addressed byte/half and extend per funct3.
  always_comb begin
    ld_byte = s_mdata_q[7:0];
    case (s_alo_q)
      2'd0: ld_byte = s_mdata_q[7:0];
      2'd1: ld_byte = s_mdata_q[15:8];
      2'd2: ld_byte = s_mdata_q[23:16];
      default: ld_byte = s_mdata_q[31:24];
    endcase
    ld_half = s_alo_q[1] ? s_mdata_q[31:16] : s_mdata_q[15:0];
    rf_wd_o = s_alu_q;
    if (s_load_q) begin
      case (s_funct3_q)
        3'b000:  rf_wd_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
        3'b001:  rf_wd_o = {{(XLEN-16){ld_half[15]}}, ld_half};
        3'b100:  rf_wd_o = {{(XLEN-8){1'b0}}, ld_byte};
        3'b101:  rf_wd_o = {{(XLEN-16){1'b0}}, ld_half};
        default: rf_wd_o = s_mdata_q;
      endcase
    end
  end

  assign rf_wv_o   = s_valid_q & s_we_q & (s_rd_q != 5'd0) & ~hold_i & ~flush_i;
  assign rf_ws_o   = s_rd_q;
  assign instret_o = instret_q;

  // Coherent operands: x0 reads zero, otherwise bypass beats the raw regfile.
  assign rd1_o = (rs1_q == 5'd0) ? '0 : (byp1_v_q ? byp1_d_q : rf_rd1_i);
  assign rd2_o = (rs2_q == 5'd0) ? '0 : (byp2_v_q ? byp2_d_q : rf_rd2_i);

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_stage                                                  |
// | Description : Self-checking bench for wb_stage: directed cases plus        |
// |               randomized traffic against an architectural model.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_v_i = 1'b0;
  logic        in_ready_o;
  logic [4:0]  in_rd_i = '0;
  logic        in_we_i = 1'b0;
  logic        in_load_i = 1'b0;
  logic [2:0]  in_funct3_i = '0;
  logic [1:0]  in_alo_i = '0;
  logic [31:0] in_alu_i = '0;
  logic [31:0] in_mdata_i = '0;
  logic        hold_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        rf_wv_o;
  logic [4:0]  rf_ws_o;
  logic [31:0] rf_wd_o;
  logic        rf_rv_i = 1'b0;
  logic [4:0]  rf_rs1_i = '0;
  logic [4:0]  rf_rs2_i = '0;
  logic [31:0] rf_rd1_i;
  logic [31:0] rf_rd2_i;
  logic [31:0] rd1_o;
  logic [31:0] rd2_o;
  logic [31:0] instret_o;

  int checks = 0;
  int passes = 0;

  wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_v_i(in_v_i), .in_ready_o(in_ready_o), .in_rd_i(in_rd_i), .in_we_i(in_we_i),
    .in_load_i(in_load_i), .in_funct3_i(in_funct3_i), .in_alo_i(in_alo_i),
    .in_alu_i(in_alu_i), .in_mdata_i(in_mdata_i), .hold_i(hold_i), .flush_i(flush_i),
    .rf_wv_o(rf_wv_o), .rf_ws_o(rf_ws_o), .rf_wd_o(rf_wd_o),
    .rf_rv_i(rf_rv_i), .rf_rs1_i(rf_rs1_i), .rf_rs2_i(rf_rs2_i),
    .rf_rd1_i(rf_rd1_i), .rf_rd2_i(rf_rd2_i),
    .rd1_o(rd1_o), .rd2_o(rd2_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Raw register file: synchronous read returning the pre-write value,
  // output held while no read strobe. Written from the DUT's write port.
  logic [31:0] ram [32];
  logic [31:0] ram_rd1 = 32'hDEADBEEF;
  logic [31:0] ram_rd2 = 32'hCAFEF00D;
  assign rf_rd1_i = ram_rd1;
  assign rf_rd2_i = ram_rd2;
  always @(posedge clk) begin
    if (rf_rv_i) begin
      ram_rd1 <= ram[rf_rs1_i];
      ram_rd2 <= ram[rf_rs2_i];
    end
    if (rf_wv_o) ram[rf_ws_o] <= rf_wd_o;
  end

  // Architectural model: one pending entry, architectural registers, counter.
  logic [31:0] arch [32];
  logic        m_v = 1'b0, m_we = 1'b0, m_load = 1'b0;
  logic [4:0]  m_rd = '0, m_rs1 = '0, m_rs2 = '0;
  logic [2:0]  m_f3 = '0;
  logic [1:0]  m_alo = '0;
  logic [31:0] m_alu = '0, m_md = '0, m_cnt = '0;

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] alo);
    logic [31:0] b, h;
    b = (w >> (8 * alo)) & 32'hFF;
    h = (w >> (16 * alo[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic exp_wv();
    return m_v && m_we && (m_rd != 0) && !hold_i && !flush_i;
  endfunction

  function automatic logic [31:0] exp_wd();
    return m_load ? load_fmt(m_md, m_f3, m_alo) : m_alu;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_v = 1'b0; m_rs1 = '0; m_rs2 = '0; m_cnt = '0;
    end else begin
      if (exp_wv()) arch[m_rd] = exp_wd();
      if (m_v && !hold_i && !flush_i) m_cnt = m_cnt + 1;
      if (rf_rv_i) begin
        m_rs1 = rf_rs1_i;
        m_rs2 = rf_rs2_i;
      end
      if (flush_i) m_v = 1'b0;
      else if (in_v_i && !hold_i) begin
        m_v = 1'b1; m_rd = in_rd_i; m_we = in_we_i; m_load = in_load_i;
        m_f3 = in_funct3_i; m_alo = in_alo_i; m_alu = in_alu_i; m_md = in_mdata_i;
      end else if (!hold_i) m_v = 1'b0;
    end
  end

  // Per-cycle comparison, mid-cycle when inputs are settled.
  always @(negedge clk) begin
    if (reset) begin
      chk("ready", {31'd0, in_ready_o}, {31'd0, !hold_i});
      chk("wv", {31'd0, rf_wv_o}, {31'd0, exp_wv()});
      if (exp_wv()) begin
        chk("ws", {27'd0, rf_ws_o}, {27'd0, m_rd});
        chk("wd", rf_wd_o, exp_wd());
      end
      chk("instret", instret_o, m_cnt);
      chk("rd1", rd1_o, (m_rs1 == 0) ? 32'd0 : arch[m_rs1]);
      chk("rd2", rd2_o, (m_rs2 == 0) ? 32'd0 : arch[m_rs2]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic ld,
                       input logic [2:0] f3, input logic [1:0] alo,
                       input logic [31:0] alu, input logic [31:0] md);
    in_v_i = 1'b1; in_rd_i = rd; in_we_i = we; in_load_i = ld;
    in_funct3_i = f3; in_alo_i = alo; in_alu_i = alu; in_mdata_i = md;
    step();
    in_v_i = 1'b0;
    #1;
  endtask

  logic [2:0]  t2_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b001, 3'b101};
  logic [1:0]  t2_alo [5] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd2};
  logic [31:0] t2_exp [5] = '{32'hFFFFFFFF, 32'h00000080, 32'h00007F01,
                              32'hFFFF80FF, 32'h000080FF};

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i]  = (i == 0) ? 32'd0 : 32'h01010101 * i + 32'h100;
      arch[i] = (i == 0) ? 32'd0 : 32'h01010101 * i + 32'h100;
    end
    repeat (3) step();
    chk("rst_wv", {31'd0, rf_wv_o}, 32'd0);
    chk("rst_instret", instret_o, 32'd0);
    chk("rst_rd1", rd1_o, 32'd0);
    chk("rst_rd2", rd2_o, 32'd0);
    reset = 1'b1;
    step();

    // T1: ALU writeback
    issue(5'd5, 1'b1, 1'b0, 3'b000, 2'd0, 32'h1234, 32'h0);
    chk("t1_wv", {31'd0, rf_wv_o}, 32'd1);
    chk("t1_ws", {27'd0, rf_ws_o}, 32'd5);
    chk("t1_wd", rf_wd_o, 32'h1234);
    step();
    chk("t1_instret", instret_o, 32'd1);

    // T2: load formatting
    for (int i = 0; i < 5; i++) begin
      issue(5'd3, 1'b1, 1'b1, t2_f3[i], t2_alo[i], 32'h0, 32'h80FF7F01);
      chk("t2_load", rf_wd_o, t2_exp[i]);
      step();
    end
    chk("t2_instret", instret_o, 32'd6);

    // T3: x0 and no-we still retire
    issue(5'd0, 1'b1, 1'b0, 3'b000, 2'd0, 32'hBAD0, 32'h0);
    chk("t3_x0_wv", {31'd0, rf_wv_o}, 32'd0);
    step();
    issue(5'd7, 1'b0, 1'b0, 3'b000, 2'd0, 32'hBAD7, 32'h0);
    chk("t3_nowe_wv", {31'd0, rf_wv_o}, 32'd0);
    step();
    chk("t3_instret", instret_o, 32'd8);

    // T4: same-cycle RAW on port 1
    issue(5'd9, 1'b1, 1'b0, 3'b000, 2'd0, 32'hAA, 32'h0);
    rf_rv_i = 1'b1; rf_rs1_i = 5'd9;
    step();
    rf_rv_i = 1'b0;
    #1;
    chk("t4_rd1", rd1_o, 32'hAA);

    // T5: write to a held read on port 2, then x0 reads
    rf_rv_i = 1'b1; rf_rs2_i = 5'd4;
    step();
    rf_rv_i = 1'b0;
    issue(5'd4, 1'b1, 1'b0, 3'b000, 2'd0, 32'h55, 32'h0);
    step();
    chk("t5_rd2", rd2_o, 32'h55);
    rf_rv_i = 1'b1; rf_rs1_i = 5'd0; rf_rs2_i = 5'd0;
    step();
    rf_rv_i = 1'b0;
    #1;
    chk("t5_x0_rd1", rd1_o, 32'd0);
    chk("t5_x0_rd2", rd2_o, 32'd0);

    // T6: hold, flush, mid-entry reset
    issue(5'd6, 1'b1, 1'b0, 3'b000, 2'd0, 32'h66, 32'h0);
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_hold_wv", {31'd0, rf_wv_o}, 32'd0);
      chk("t6_hold_cnt", instret_o, 32'd10);
      step();
    end
    hold_i = 1'b0;
    #1;
    chk("t6_rel_wv", {31'd0, rf_wv_o}, 32'd1);
    chk("t6_rel_wd", rf_wd_o, 32'h66);
    step();
    chk("t6_rel_cnt", instret_o, 32'd11);
    issue(5'd6, 1'b1, 1'b0, 3'b000, 2'd0, 32'h77, 32'h0);
    flush_i = 1'b1;
    #1;
    chk("t6_flush_wv", {31'd0, rf_wv_o}, 32'd0);
    step();
    flush_i = 1'b0;
    #1;
    chk("t6_post_flush_wv", {31'd0, rf_wv_o}, 32'd0);
    chk("t6_flush_cnt", instret_o, 32'd11);
    step();
    issue(5'd8, 1'b1, 1'b0, 3'b000, 2'd0, 32'h88, 32'h0);
    chk("t6_pre_rst_wv", {31'd0, rf_wv_o}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_wv", {31'd0, rf_wv_o}, 32'd0);
    chk("t6_rst_cnt", instret_o, 32'd0);
    step();
    reset = 1'b1;
    step();

    // Randomized traffic; small register range to provoke bypass hits.
    for (int n = 0; n < 3000; n++) begin
      in_v_i      = ($urandom_range(0, 9) < 7);
      in_rd_i     = 5'($urandom_range(0, 7));
      in_we_i     = ($urandom_range(0, 7) != 0);
      in_load_i   = $urandom_range(0, 1) == 1;
      in_funct3_i = 3'($urandom_range(0, 7));
      in_alo_i    = 2'($urandom_range(0, 3));
      in_alu_i    = $urandom;
      in_mdata_i  = $urandom;
      hold_i      = ($urandom_range(0, 9) == 0);
      flush_i     = ($urandom_range(0, 19) == 0);
      rf_rv_i     = $urandom_range(0, 1) == 1;
      rf_rs1_i    = 5'($urandom_range(0, 7));
      rf_rs2_i    = 5'($urandom_range(0, 7));
      step();
    end
    in_v_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0; rf_rv_i = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
